// File: rtl/sockit_spi_fifo.sv
// Single-clock FIFO for SPI transfer data with valid/ready handshake on both ports.
// Adds an exact fill level, programmable almost-full/almost-empty flags and sticky error flags.
module sockit_spi_fifo #(
  parameter int unsigned CW = 2,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] fii_dat,
  input  logic          fii_vld,
  output logic          fii_rdy,
  output logic [DW-1:0] fio_dat,
  output logic          fio_vld,
  input  logic          fio_rdy,
  input  logic [CW:0]   cfg_afl,
  input  logic [CW:0]   cfg_aem,
  output logic [CW:0]   sts_lvl,
  output logic          sts_afl,
  output logic          sts_aem,
  output logic          sts_ovf,
  output logic          sts_unf
);

  localparam int unsigned DEPTH    = 2**CW;
  localparam logic [CW:0] LVL_FULL = (CW+1)'(DEPTH);

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW:0]   lvl;
  logic          ovf;
  logic          unf;
  logic [DW-1:0] mem [DEPTH];

  logic fii_trn;
  logic fio_trn;

  // Handshake outputs come from the level register only, so there is no
  // combinational path from fii_vld or fio_rdy.
  assign fii_rdy = (lvl != LVL_FULL);
  assign fio_vld = (lvl != '0);
  assign fii_trn = fii_vld & fii_rdy;
  assign fio_trn = fio_vld & fio_rdy;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // in this block samples the pre-edge values of its neighbours.
      if (fii_trn) wr_ptr <= wr_ptr + 1'b1;
      if (fio_trn) rd_ptr <= rd_ptr + 1'b1;
      case ({fii_trn, fio_trn})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
      if (fii_vld && !fii_rdy) ovf <= 1'b1;
      if (fio_rdy && !fio_vld) unf <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by the level
  // counter, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (fii_trn && !clr && !rst) mem[wr_ptr] <= fii_dat;
  end

  assign fio_dat = mem[rd_ptr];

  assign sts_lvl = lvl;
  assign sts_afl = (lvl >= cfg_afl);
  assign sts_aem = (lvl <= cfg_aem);
  assign sts_ovf = ovf;
  assign sts_unf = unf;

endmodule

// File: tb/tb_sockit_spi_fifo.sv
// Self-checking bench for sockit_spi_fifo: a reference queue model predicts
// handshakes, data order, level and flags each cycle.
module tb_sockit_spi_fifo;

  localparam int CW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 2**CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic [DW-1:0] fii_dat;
  logic          fii_vld;
  logic          fii_rdy;
  logic [DW-1:0] fio_dat;
  logic          fio_vld;
  logic          fio_rdy;
  logic [CW:0]   cfg_afl;
  logic [CW:0]   cfg_aem;
  logic [CW:0]   sts_lvl;
  logic          sts_afl;
  logic          sts_aem;
  logic          sts_ovf;
  logic          sts_unf;

  sockit_spi_fifo #(.CW(CW), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .fii_dat (fii_dat),
    .fii_vld (fii_vld),
    .fii_rdy (fii_rdy),
    .fio_dat (fio_dat),
    .fio_vld (fio_vld),
    .fio_rdy (fio_rdy),
    .cfg_afl (cfg_afl),
    .cfg_aem (cfg_aem),
    .sts_lvl (sts_lvl),
    .sts_afl (sts_afl),
    .sts_aem (sts_aem),
    .sts_ovf (sts_ovf),
    .sts_unf (sts_unf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [DW-1:0] sb_q[$];
  bit            mdl_ovf;
  bit            mdl_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle: compare the pre-edge outputs against the model, then
  // advance both model and DUT across one rising edge.
  task automatic cycle(input bit vld, input logic [DW-1:0] dat, input bit rdy, input bit do_clr);
    int  lvl;
    bit  full;
    bit  empty;
    fii_vld = vld;
    fii_dat = dat;
    fio_rdy = rdy;
    clr     = do_clr;
    #1;
    lvl   = sb_q.size();
    full  = (lvl == DEPTH);
    empty = (lvl == 0);
    check("fii_rdy", 32'(fii_rdy), 32'(!full));
    check("fio_vld", 32'(fio_vld), 32'(!empty));
    check("sts_lvl", 32'(sts_lvl), 32'(lvl));
    check("sts_afl", 32'(sts_afl), 32'(lvl >= int'(cfg_afl)));
    check("sts_aem", 32'(sts_aem), 32'(lvl <= int'(cfg_aem)));
    check("sts_ovf", 32'(sts_ovf), 32'(mdl_ovf));
    check("sts_unf", 32'(sts_unf), 32'(mdl_unf));
    if (!empty) check("fio_dat", 32'(fio_dat), 32'(sb_q[0]));
    if (do_clr) begin
      sb_q.delete();
      mdl_ovf = 1'b0;
      mdl_unf = 1'b0;
    end else begin
      if (vld && full) mdl_ovf = 1'b1;
      if (rdy && empty) mdl_unf = 1'b1;
      if (rdy && !empty) void'(sb_q.pop_front());
      if (vld && !full) sb_q.push_back(dat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH && sb_q.size() != 0; i++) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    rst     = 1'b1;
    clr     = 1'b0;
    fii_vld = 1'b0;
    fii_dat = '0;
    fio_rdy = 1'b0;
    cfg_afl = 3'd3;
    cfg_aem = 3'd1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mdl_ovf = 1'b0;
    mdl_unf = 1'b0;

    // Reset state and threshold flags at level 0.
    check("rst_lvl", 32'(sts_lvl), 32'd0);
    check("rst_rdy", 32'(fii_rdy), 32'd1);
    check("rst_vld", 32'(fio_vld), 32'd0);

    // Fill without reading; full on the 4th edge.
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    cycle(1'b1, 8'h44, 1'b0, 1'b0);
    check("full_rdy", 32'(fii_rdy), 32'd0);
    check("full_lvl", 32'(sts_lvl), 32'd4);

    // Drain in order; fio_rdy drops with the last read, so no underflow.
    drain();
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("drain_unf", 32'(sts_unf), 32'd0);

    // Wrap-around: ten words interleaved with reads.
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(i), (i > 0), 1'b0);
    drain();
    check("wrap_lvl", 32'(sts_lvl), 32'd0);

    // Full with simultaneous read and write: write refused, ovf set.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    check("ovf_lvl", 32'(sts_lvl), 32'd3);
    check("ovf_set", 32'(sts_ovf), 32'd1);
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    check("ovf_refill", 32'(sts_lvl), 32'd4);

    // Threshold corner values at level 4.
    cfg_afl = 3'd5; cfg_aem = 3'd4;
    cycle(1'b0, '0, 1'b0, 1'b0);
    cfg_afl = 3'd0; cfg_aem = 3'd3;
    cycle(1'b0, '0, 1'b0, 1'b0);
    cfg_afl = 3'd3; cfg_aem = 3'd1;
    drain();

    // Underflow: read request while empty.
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("unf_set", 32'(sts_unf), 32'd1);

    // Threshold walk 0..3 with afl=3, aem=1, then clear at level 2.
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    cycle(1'b1, 8'h02, 1'b0, 1'b0);
    cycle(1'b1, 8'h03, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 8'h77, 1'b1, 1'b1);
    check("clr_lvl", 32'(sts_lvl), 32'd0);
    check("clr_vld", 32'(fio_vld), 32'd0);
    check("clr_ovf", 32'(sts_ovf), 32'd0);
    check("clr_unf", 32'(sts_unf), 32'd0);

    // Post-clear write and readback.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    check("a5_dat", 32'(fio_dat), 32'hA5);
    drain();
    cycle(1'b0, '0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
